if1b: RTL and testbench
=======================

IF1B -- requirements
Module: if1b

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter FIRST_EXP, default 10'h000: the counter value expected in the first accepted transfer after reset.
REQ-002 The block SHALL have parameter ERR_SAT, default 8'hFF: the saturation value of the error counter.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port if1b_valid_in, input, 1: the upstream (stage 1a) transfer is valid.
REQ-006 The block SHALL have port if1b_counter_in, input, 10: the upstream counter; meaningful only while if1b_valid_in=1.
REQ-007 The block SHALL have port if1b_ready_out, output, 1: upstream backpressure; 1 means this block accepts on this edge.
REQ-008 The block SHALL have port if1b_valid_out, output, 1: a downstream entry is present.
REQ-009 The block SHALL have port if1b_counter_out, output, 10: the downstream counter (head of FIFO).
REQ-010 The block SHALL have port if1b_ready_in, input, 1: the downstream accepts on this edge.
REQ-011 The block SHALL have port if1b_err_out, output, 1: sticky sequence-error flag.
REQ-012 The block SHALL have port if1b_errcnt_out, output, 8: the number of sequence errors, saturating.
REQ-013 The block SHALL have port if1b_xfercnt_out, output, 16: the number of accepted upstream transfers, wrapping.

Function
REQ-014 Upstream accept SHALL occur on an edge where if1b_valid_in=1 and if1b_ready_out=1; the upstream holds valid and counter while ready_out=0.
REQ-015 Downstream pop SHALL occur on an edge where if1b_valid_out=1 and if1b_ready_in=1.
REQ-016 Storage SHALL be a 2-entry FIFO with a registered occupancy count of 0..2.
REQ-017 if1b_ready_out SHALL equal ready_en AND (count != 2), where ready_en is a flag cleared by reset and set on the first edge after reset deassertion; it SHALL NOT depend combinationally on if1b_ready_in.
REQ-018 if1b_valid_out SHALL equal (count != 0).
REQ-019 if1b_counter_out SHALL present the head entry when valid and 10'h000 when count=0; it SHALL never be X.
REQ-020 Simultaneous accept and pop with count=1 SHALL leave count at 1, with the new entry becoming head on the next cycle.
REQ-021 Simultaneous accept and pop with count=0 SHALL be impossible, because valid_out=0; accept alone SHALL set count to 1.
REQ-022 With count=2 no accept SHALL occur; a pop SHALL reduce count to 1 and raise ready_out on the next cycle.
REQ-023 Latency SHALL be as follows: an entry accepted into an empty FIFO appears on valid_out/counter_out in the next cycle (1-cycle latency); FIFO order is preserved.
REQ-024 The sequence check SHALL keep a 10-bit register exp, reset to FIFO_EXP... specifically to FIRST_EXP; on each accept, if counter_in != exp, it SHALL flag an error.
REQ-025 On each accept, exp SHALL be set to counter_in + 1 modulo 1024, whether or not an error occurred (resynchronisation); 10'h3FF SHALL be followed by 10'h000 without error.
REQ-026 On an error, if1b_err_out SHALL set to 1 and remain set until reset.
REQ-027 On an error, if1b_errcnt_out SHALL increment by 1 unless it already equals ERR_SAT, in which case it SHALL hold.
REQ-028 if1b_xfercnt_out SHALL increment by 1 on every accept and wrap from 16'hFFFF to 16'h0000.
REQ-029 Inputs on edges without an accept SHALL be ignored; X on if1b_counter_in while if1b_valid_in=0 SHALL not affect state.

Reset
REQ-030 Asserting rst SHALL immediately force the following, independent of clk:
- count=0
- ready_en=0, so ready_out=0
- valid_out=0
- counter_out=10'h000
- exp=FIRST_EXP
- err_out=0
- errcnt_out=8'h00
- xfercnt_out=16'h0000
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents; ready_out SHALL rise one clock edge after rst falls.

Verification
REQ-032 Bench scenario, reset release then stream: ready_in=1, valid_in=1 with counters 0,1,2 back-to-back -> counter_out 0,1,2 one cycle after each accept; err_out=0; xfercnt_out=3.
REQ-033 Bench scenario, backpressure: ready_in=0 with three offered transfers -> two accepted, ready_out=0, count=2. Then ready_in=1 -> drain in order, and ready_out returns to 1 the cycle after the first pop.
REQ-034 Bench scenario, sequence error: accept 0,1,5,6 -> errcnt_out=1 after the 5; no error on the 6; err_out stays 1.
REQ-035 Bench scenario, wrap: preload the stream 3FE,3FF,000 after exp is synced -> no error increment on the wrap.
REQ-036 Bench scenario, saturation: force 300 consecutive mismatches (e.g. a constant counter_in) -> errcnt_out=8'hFF and holds.
REQ-037 Bench scenario, async reset mid-stream with count=2: assert rst between edges -> valid_out, ready_out and all counters are 0 immediately; after release the first accept is checked against FIRST_EXP.

Source files
------------

// File: rtl/if1b.sv
// Stage-1b sink: 2-entry FIFO between the 1a upstream and the downstream, with a
// sequence check on the incoming counter and transfer/error statistics.
module if1b #(
  parameter logic [9:0] FIRST_EXP = 10'h000,
  parameter logic [7:0] ERR_SAT   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if1b_valid_in,
  input  logic [9:0]  if1b_counter_in,
  output logic        if1b_ready_out,
  output logic        if1b_valid_out,
  output logic [9:0]  if1b_counter_out,
  input  logic        if1b_ready_in,
  output logic        if1b_err_out,
  output logic [7:0]  if1b_errcnt_out,
  output logic [15:0] if1b_xfercnt_out
);

  localparam int unsigned CW = 10;
  localparam int unsigned EW = 8;
  localparam int unsigned XW = 16;
  localparam int unsigned NW = 2;

  logic [NW-1:0] count;
  logic          ready_en;
  logic [CW-1:0] slot0;
  logic [CW-1:0] slot1;
  logic [CW-1:0] exp_q;
  logic          accept;
  logic          pop;

  // Status outputs are pure decodes of registered state; no path from ready_in.
  assign if1b_ready_out   = ready_en && (count != NW'(2));
  assign if1b_valid_out   = (count != NW'(0));
  assign if1b_counter_out = if1b_valid_out ? slot0 : CW'(0);

  assign accept = if1b_valid_in && if1b_ready_out;
  assign pop    = if1b_valid_out && if1b_ready_in;

  // FIFO storage: slot0 is always the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      ready_en <= 1'b0;
      slot0    <= '0;
      slot1    <= '0;
    end else begin
      ready_en <= 1'b1;
      case ({accept, pop})
        2'b01: begin
          slot0 <= slot1;
          count <= count - NW'(1);
        end
        2'b10: begin
          if (count == NW'(0)) slot0 <= if1b_counter_in;
          else                 slot1 <= if1b_counter_in;
          count <= count + NW'(1);
        end
        // Only reachable with one entry: the newcomer replaces the popped head.
        2'b11: slot0 <= if1b_counter_in;
        default: ;
      endcase
    end
  end

  // Sequence check resynchronises on every accept, error or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q            <= FIRST_EXP;
      if1b_err_out     <= 1'b0;
      if1b_errcnt_out  <= '0;
      if1b_xfercnt_out <= '0;
    end else if (accept) begin
      exp_q            <= if1b_counter_in + CW'(1);
      if1b_xfercnt_out <= if1b_xfercnt_out + XW'(1);
      if (if1b_counter_in != exp_q) begin
        if1b_err_out <= 1'b1;
        if (if1b_errcnt_out != ERR_SAT) if1b_errcnt_out <= if1b_errcnt_out + EW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if1b.sv
// Bench for if1b: directed scenarios plus randomized traffic, checked against a
// queue-based transaction model of the FIFO and sequence statistics.
module tb_if1b;

  localparam logic [9:0] FE  = 10'h000;
  localparam logic [7:0] SAT = 8'hFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [9:0]  cin = '0;
  logic        rin = 1'b0;
  logic        ready_out;
  logic        valid_out;
  logic [9:0]  counter_out;
  logic        err_out;
  logic [7:0]  errcnt_out;
  logic [15:0] xfercnt_out;

  int passed = 0;
  int total  = 0;

  // Model state
  int q[$];
  int m_exp;
  bit m_ready_en;
  bit m_err;
  int m_errcnt;
  int m_xfer;
  bit m_acc;

  if1b #(.FIRST_EXP(FE), .ERR_SAT(SAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .if1b_valid_in    (vin),
    .if1b_counter_in  (cin),
    .if1b_ready_out   (ready_out),
    .if1b_valid_out   (valid_out),
    .if1b_counter_out (counter_out),
    .if1b_ready_in    (rin),
    .if1b_err_out     (err_out),
    .if1b_errcnt_out  (errcnt_out),
    .if1b_xfercnt_out (xfercnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic model_reset();
    q.delete();
    m_exp      = int'(FE);
    m_ready_en = 1'b0;
    m_err      = 1'b0;
    m_errcnt   = 0;
    m_xfer     = 0;
    m_acc      = 1'b0;
  endtask

  task automatic check_all();
    check("ready_out",   32'(ready_out),   32'(m_ready_en && q.size() < 2));
    check("valid_out",   32'(valid_out),   32'(q.size() != 0));
    check("counter_out", 32'(counter_out), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("err_out",     32'(err_out),     32'(m_err));
    check("errcnt_out",  32'(errcnt_out),  32'(m_errcnt));
    check("xfercnt_out", 32'(xfercnt_out), 32'(m_xfer));
  endtask

  // One clock: drive inputs, advance the model by the transaction rules, check.
  task automatic step(input logic v, input logic [9:0] c, input logic r);
    bit acc;
    bit pp;
    int cv;
    vin = v;
    cin = v ? c : 10'bx;
    rin = r;
    acc = v && m_ready_en && (q.size() < 2);
    pp  = (q.size() != 0) && r;
    cv  = int'(c);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(cv);
      if (cv != m_exp) begin
        m_err = 1'b1;
        if (m_errcnt < int'(SAT)) m_errcnt++;
      end
      m_exp  = (cv + 1) % 1024;
      m_xfer = (m_xfer + 1) % 65536;
    end
    m_ready_en = 1'b1;
    m_acc      = acc;
    #1;
    check_all();
  endtask

  initial begin
    logic       rv;
    logic [9:0] rc;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_all();
    rst = 1'b0;
    #1;
    check("ready_low_after_release", 32'(ready_out), 32'd0);

    // Stream 0,1,2 back-to-back
    step(1'b1, 10'd0, 1'b1);
    step(1'b1, 10'd0, 1'b1);
    step(1'b1, 10'd1, 1'b1);
    step(1'b1, 10'd2, 1'b1);
    step(1'b0, 10'd0, 1'b1);
    check("stream_xfercnt", 32'(xfercnt_out), 32'd3);
    check("stream_err", 32'(err_out), 32'd0);

    // Backpressure: three offers, two accepted, then drain
    step(1'b1, 10'd3, 1'b0);
    step(1'b1, 10'd4, 1'b0);
    step(1'b1, 10'd5, 1'b0);
    check("bp_full_ready", 32'(ready_out), 32'd0);
    step(1'b1, 10'd5, 1'b1);
    check("bp_ready_after_pop", 32'(ready_out), 32'd1);
    step(1'b1, 10'd5, 1'b1);
    step(1'b0, 10'd0, 1'b1);
    step(1'b0, 10'd0, 1'b1);

    // Sequence error then resync
    step(1'b1, 10'd6, 1'b1);
    step(1'b1, 10'd7, 1'b1);
    step(1'b1, 10'd11, 1'b1);
    check("seq_errcnt", 32'(errcnt_out), 32'd1);
    step(1'b1, 10'd12, 1'b1);
    check("seq_no_new_err", 32'(errcnt_out), 32'd1);
    check("seq_sticky", 32'(err_out), 32'd1);

    // Wrap 3FE,3FF,000 after syncing on 3FD
    step(1'b1, 10'h3FD, 1'b1);
    step(1'b1, 10'h3FE, 1'b1);
    step(1'b1, 10'h3FF, 1'b1);
    step(1'b1, 10'h000, 1'b1);
    check("wrap_errcnt", 32'(errcnt_out), 32'd2);
    step(1'b0, 10'd0, 1'b1);

    // Randomized traffic; upstream holds its offer until accepted
    rv = 1'b0;
    rc = '0;
    for (int i = 0; i < 400; i++) begin
      if (!rv || m_acc) begin
        rv = ($urandom % 4) != 0;
        rc = (($urandom % 8) == 0) ? 10'($urandom) : 10'(m_exp);
      end
      step(rv, rc, 1'(($urandom % 3) != 0));
    end
    step(1'b0, 10'd0, 1'b1);
    step(1'b0, 10'd0, 1'b1);

    // Saturation: constant counter mismatches
    for (int i = 0; i < 300; i++) step(1'b1, 10'h155, 1'b1);
    check("sat_errcnt", 32'(errcnt_out), 32'(SAT));
    step(1'b1, 10'h155, 1'b1);
    check("sat_hold", 32'(errcnt_out), 32'(SAT));

    // Async reset mid-stream with the FIFO full
    step(1'b0, 10'd0, 1'b1);
    step(1'b1, 10'h100, 1'b0);
    step(1'b1, 10'h101, 1'b0);
    check("full_before_reset", 32'(ready_out), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3;
    rst = 1'b0;
    #1;
    check("ready_low_after_rerelease", 32'(ready_out), 32'd0);
    step(1'b1, FE, 1'b1);
    step(1'b1, FE, 1'b1);
    step(1'b1, FE + 10'd1, 1'b1);
    step(1'b0, 10'd0, 1'b1);
    check("post_reset_err", 32'(err_out), 32'd0);
    check("post_reset_xfer", 32'(xfercnt_out), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
